// File: rtl/glb_banked_buffer_pkg.sv
// -----------------------------------------------------------------------------
// glb_banked_buffer_pkg
// Shared constants and helpers for the global buffer. TOP_ctrl and PE_array
// import the same package so their bank-select and address widths always
// match the buffer.
//   clogb2(x)           : number of bits needed to represent x (0 for x == 0)
//   GLB_DATA_BITWIDTH   : default word width of every bank entry
//   GLB_BANK_NUM        : default number of banks
//   GLB_BANK_DEPTH      : default words per bank
//   glb_bank_e          : conventional bank identifiers
// -----------------------------------------------------------------------------
package glb_banked_buffer_pkg;

  function automatic int clogb2(input int x);
    int n;
    int v;
    n = 0;
    v = x;
    while (v > 0) begin
      n = n + 1;
      v = v >> 1;
    end
    return n;
  endfunction

  localparam int GLB_DATA_BITWIDTH = 32;
  localparam int GLB_BANK_NUM      = 3;
  localparam int GLB_BANK_DEPTH    = 512;
  localparam int GLB_SEL_W         = clogb2(GLB_BANK_NUM - 1);
  localparam int GLB_ADDR_W        = clogb2(GLB_BANK_DEPTH - 1);

  typedef enum logic [1:0] {
    BANK_IFMAP  = 2'd0,
    BANK_PSUM   = 2'd1,
    BANK_WEIGHT = 2'd2
  } glb_bank_e;

endpackage

// File: rtl/glb_banked_buffer_bank.sv
// -----------------------------------------------------------------------------
// glb_bank
// One block-RAM bank of the global buffer with a registered (1-cycle) read.
// The memory array carries no reset so it maps onto block RAM; only the read
// register is cleared by the asynchronous reset. Read-first behaviour on a
// same-address read/write falls out of the non-blocking update order.
//   i_clk  : clock (rising edge)
//   i_rst  : asynchronous active-high reset of the read register
//   i_re   : read enable, captures BRAM[i_ra] into the read register
//   i_we   : write enable, BRAM[i_wa] <= i_wd
//   i_ra   : read address
//   i_wa   : write address
//   i_wd   : write data
//   o_rd   : read register contents
// -----------------------------------------------------------------------------
module glb_bank
  import glb_banked_buffer_pkg::*;
#(
  parameter  int DATA_BITWIDTH = GLB_DATA_BITWIDTH,
  parameter  int BANK_DEPTH    = GLB_BANK_DEPTH,
  localparam int ADDR_W        = clogb2(BANK_DEPTH - 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_re,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_ra,
  input  logic [ADDR_W-1:0]        i_wa,
  input  logic [DATA_BITWIDTH-1:0] i_wd,
  output logic [DATA_BITWIDTH-1:0] o_rd
);

  // Name kept as BRAM so testbenches can preload it hierarchically.
  logic [DATA_BITWIDTH-1:0] BRAM [0:BANK_DEPTH-1];
  logic [DATA_BITWIDTH-1:0] rd_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      BRAM[i_wa] <= i_wd;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_q <= '0;
    end else if (i_re) begin
      rd_q <= BRAM[i_ra];
    end
  end

  assign o_rd = rd_q;

endmodule

// File: rtl/glb_banked_buffer.sv
// -----------------------------------------------------------------------------
// glb_banked_buffer
// Global buffer: BANK_NUM independent BRAM banks (ifmap, psum, weight). One
// bank is selected per cycle for both read and write; read data appears on
// o_rd one cycle after i_re is sampled and holds while i_re is low.
//   i_clk      : clock (rising edge)
//   i_rst      : asynchronous active-high reset (memory contents kept)
//   i_bank_sel : bank targeted by this cycle's read and write
//   i_re       : read enable
//   i_we       : write enable
//   i_ra       : read address within the selected bank
//   i_wa       : write address within the selected bank
//   i_wd       : write data (psum from PE_array)
//   o_rd       : read data of the last read bank, 0 for an out-of-range select
// -----------------------------------------------------------------------------
module glb_banked_buffer
  import glb_banked_buffer_pkg::*;
#(
  parameter  int DATA_BITWIDTH = GLB_DATA_BITWIDTH,
  parameter  int BANK_NUM      = GLB_BANK_NUM,
  parameter  int BANK_DEPTH    = GLB_BANK_DEPTH,
  // A single bank still needs a 1-bit select port.
  localparam int SEL_W         = (BANK_NUM > 1) ? clogb2(BANK_NUM - 1) : 1,
  localparam int ADDR_W        = clogb2(BANK_DEPTH - 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [SEL_W-1:0]         i_bank_sel,
  input  logic                     i_re,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_ra,
  input  logic [ADDR_W-1:0]        i_wa,
  input  logic [DATA_BITWIDTH-1:0] i_wd,
  output logic [DATA_BITWIDTH-1:0] o_rd
);

  logic [DATA_BITWIDTH-1:0] bank_rd [BANK_NUM];
  logic [SEL_W-1:0]         rd_sel_q;
  logic [SEL_W-1:0]         rd_sel_d;

  genvar gi;
  generate
    for (gi = 0; gi < BANK_NUM; gi++) begin : gen_GLB_BANKS
      logic bank_re;
      logic bank_we;

      // An out-of-range select matches no bank, so such writes are dropped.
      assign bank_re = i_re && (i_bank_sel == SEL_W'(gi));
      assign bank_we = i_we && (i_bank_sel == SEL_W'(gi));

      glb_bank #(
        .DATA_BITWIDTH (DATA_BITWIDTH),
        .BANK_DEPTH    (BANK_DEPTH)
      ) glb_bank_inst (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_re  (bank_re),
        .i_we  (bank_we),
        .i_ra  (i_ra),
        .i_wa  (i_wa),
        .i_wd  (i_wd),
        .o_rd  (bank_rd[gi])
      );
    end
  endgenerate

  // The select is captured even when out of range so o_rd goes to 0.
  assign rd_sel_d = i_re ? i_bank_sel : rd_sel_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_sel_q <= '0;
    end else begin
      rd_sel_q <= rd_sel_d;
    end
  end

  always_comb begin
    o_rd = '0;
    for (int k = 0; k < BANK_NUM; k++) begin
      if (rd_sel_q == SEL_W'(k)) begin
        o_rd = bank_rd[k];
      end
    end
  end

endmodule

// File: tb/tb_glb_banked_buffer.sv
// -----------------------------------------------------------------------------
// tb_glb_banked_buffer
// Directed, table-driven bench for glb_banked_buffer. Each table row is one
// clock cycle of stimulus; rows with chk set compare o_rd after the edge.
// Hand-written sequences cover reset, read-hold and asynchronous reset during
// an access.
// -----------------------------------------------------------------------------
module tb_glb_banked_buffer;

  logic        clk;
  logic        rst;
  logic [1:0]  bank_sel;
  logic        re;
  logic        we;
  logic [8:0]  ra;
  logic [8:0]  wa;
  logic [31:0] wd;
  logic [31:0] rd;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [1:0]  sel;
    logic        re;
    logic        we;
    logic [8:0]  ra;
    logic [8:0]  wa;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  glb_banked_buffer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_bank_sel (bank_sel),
    .i_re       (re),
    .i_we       (we),
    .i_ra       (ra),
    .i_wa       (wa),
    .i_wd       (wd),
    .o_rd       (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: o_rd=%h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: o_rd=%h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bank_sel = 2'd0; re = 1'b0; we = 1'b0; ra = '0; wa = '0; wd = '0;
  endtask

  function automatic vec_t mk(input logic [1:0] s, input logic r, input logic w,
                              input logic [8:0] a_r, input logic [8:0] a_w,
                              input logic [31:0] d, input logic c, input logic [31:0] e);
    vec_t v;
    v.sel = s; v.re = r; v.we = w; v.ra = a_r; v.wa = a_w;
    v.wd = d; v.chk = c; v.exp = e;
    return v;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // sel  re  we  ra  wa  wd  chk exp
    vecs.push_back(mk(2'd0, 0, 1, 9'd0,   9'd0,   32'hA000_0000, 0, 32'h0));
    vecs.push_back(mk(2'd2, 0, 1, 9'd0,   9'd5,   32'hC000_0005, 0, 32'h0));
    vecs.push_back(mk(2'd0, 0, 1, 9'd0,   9'd7,   32'hA000_0007, 0, 32'h0));
    vecs.push_back(mk(2'd2, 0, 1, 9'd0,   9'd7,   32'hC000_0007, 0, 32'h0));
    vecs.push_back(mk(2'd1, 0, 1, 9'd0,   9'd3,   32'h0000_0011, 0, 32'h0));
    // back-to-back reads of two different banks
    vecs.push_back(mk(2'd0, 1, 0, 9'd0,   9'd0,   32'h0,         1, 32'hA000_0000));
    vecs.push_back(mk(2'd2, 1, 0, 9'd5,   9'd0,   32'h0,         1, 32'hC000_0005));
    // psum write then read back; neighbouring banks untouched
    vecs.push_back(mk(2'd1, 0, 1, 9'd0,   9'd7,   32'hCAFE_0001, 1, 32'hC000_0005));
    vecs.push_back(mk(2'd1, 1, 0, 9'd7,   9'd0,   32'h0,         1, 32'hCAFE_0001));
    vecs.push_back(mk(2'd0, 1, 0, 9'd7,   9'd0,   32'h0,         1, 32'hA000_0007));
    vecs.push_back(mk(2'd2, 1, 0, 9'd7,   9'd0,   32'h0,         1, 32'hC000_0007));
    // same-cycle read/write of the same word: old value first
    vecs.push_back(mk(2'd1, 1, 1, 9'd3,   9'd3,   32'h0000_0022, 1, 32'h0000_0011));
    vecs.push_back(mk(2'd1, 1, 0, 9'd3,   9'd0,   32'h0,         1, 32'h0000_0022));
    // out-of-range select: write dropped, read yields 0
    vecs.push_back(mk(2'd3, 0, 1, 9'd0,   9'd7,   32'hFFFF_FFFF, 1, 32'h0000_0022));
    vecs.push_back(mk(2'd3, 1, 0, 9'd7,   9'd0,   32'h0,         1, 32'h0));
    vecs.push_back(mk(2'd0, 1, 0, 9'd7,   9'd0,   32'h0,         1, 32'hA000_0007));
    vecs.push_back(mk(2'd1, 1, 0, 9'd7,   9'd0,   32'h0,         1, 32'hCAFE_0001));
    vecs.push_back(mk(2'd2, 1, 0, 9'd7,   9'd0,   32'h0,         1, 32'hC000_0007));
    // top address of every bank
    vecs.push_back(mk(2'd0, 0, 1, 9'd0,   9'd511, 32'hD000_01FF, 0, 32'h0));
    vecs.push_back(mk(2'd1, 0, 1, 9'd0,   9'd511, 32'hD100_01FF, 0, 32'h0));
    vecs.push_back(mk(2'd2, 0, 1, 9'd0,   9'd511, 32'hD200_01FF, 0, 32'h0));
    vecs.push_back(mk(2'd0, 1, 0, 9'd511, 9'd0,   32'h0,         1, 32'hD000_01FF));
    vecs.push_back(mk(2'd1, 1, 0, 9'd511, 9'd0,   32'h0,         1, 32'hD100_01FF));
    vecs.push_back(mk(2'd2, 1, 0, 9'd511, 9'd0,   32'h0,         1, 32'hD200_01FF));
    // read and write different addresses of one bank in the same cycle
    vecs.push_back(mk(2'd0, 1, 1, 9'd511, 9'd0,   32'h1234_5678, 1, 32'hD000_01FF));
    vecs.push_back(mk(2'd0, 1, 0, 9'd0,   9'd0,   32'h0,         1, 32'h1234_5678));
    vecs.push_back(mk(2'd2, 1, 0, 9'd0,   9'd0,   32'h0,         1, 32'h0000_0000));

    // Reset held for 10 cycles, o_rd checked each cycle.
    idle();
    rst = 1'b1;
    #1;
    check("reset_t0", rd, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("reset_hold%0d", i), rd, 32'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_reset_idle%0d", i), rd, 32'h0);
    end

    // Bank 2 word 0 is written so the last table row reads a defined value.
    bank_sel = 2'd2; we = 1'b1; wa = 9'd0; wd = 32'h0;
    tick();
    idle();

    for (int i = 0; i < vecs.size(); i++) begin
      bank_sel = vecs[i].sel;
      re       = vecs[i].re;
      we       = vecs[i].we;
      ra       = vecs[i].ra;
      wa       = vecs[i].wa;
      wd       = vecs[i].wd;
      tick();
      if (vecs[i].chk) check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    idle();

    // Read then hold with i_re low while select/address wander.
    bank_sel = 2'd1; re = 1'b1; ra = 9'd7;
    tick();
    check("hold_load", rd, 32'hCAFE_0001);
    re = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bank_sel = 2'(i % 3);
      ra       = 9'(i * 100 + 3);
      tick();
      check($sformatf("hold%0d", i), rd, 32'hCAFE_0001);
    end

    // Asynchronous reset in the middle of a cycle clears o_rd at once.
    bank_sel = 2'd2; re = 1'b1; ra = 9'd5;
    tick();
    check("pre_async_rst", rd, 32'hC000_0005);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_immediate", rd, 32'h0);
    tick();
    check("async_rst_held", rd, 32'h0);
    rst = 1'b0;
    tick();
    check("mem_kept_after_rst", rd, 32'hC000_0005);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
